// File: rtl/alu_regfile_datapath_pkg.sv
// rtl/alu_regfile_datapath_pkg.sv - shared widths, ALU opcodes and source-select encodings
package alu_regfile_datapath_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int ADDR_W_DEF = 4;

    localparam logic [3:0] ALU_ADD  = 4'h0;
    localparam logic [3:0] ALU_SUB  = 4'h1;
    localparam logic [3:0] ALU_AND  = 4'h2;
    localparam logic [3:0] ALU_OR   = 4'h3;
    localparam logic [3:0] ALU_XOR  = 4'h4;
    localparam logic [3:0] ALU_NOT  = 4'h5;
    localparam logic [3:0] ALU_SHL  = 4'h6;
    localparam logic [3:0] ALU_SHR  = 4'h7;
    localparam logic [3:0] ALU_PASA = 4'h8;
    localparam logic [3:0] ALU_PASB = 4'h9;
    localparam logic [3:0] ALU_INC  = 4'hA;
    localparam logic [3:0] ALU_DEC  = 4'hB;
    localparam logic [3:0] ALU_SLT  = 4'hC;
    localparam logic [3:0] ALU_SEQ  = 4'hD;
    localparam logic [3:0] ALU_NEG  = 4'hE;
    localparam logic [3:0] ALU_CLR  = 4'hF;

    // Select encodings shared by the write-back and operand muxes
    localparam logic SRC_ALU = 1'b0;
    localparam logic SRC_EXT = 1'b1;

endpackage

// File: rtl/alu_regfile_datapath_if.sv
// rtl/alu_regfile_datapath_if.sv - decoder-to-datapath control and status bundle
interface alu_regfile_datapath_if
    import alu_regfile_datapath_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
);
    logic              writeEnable;
    logic              writeSourceSelect;
    logic              muxASelect;
    logic              muxBSelect;
    logic [DATA_W-1:0] extInputData;
    logic [ADDR_W-1:0] destAddress;
    logic [ADDR_W-1:0] aAddress;
    logic [ADDR_W-1:0] bAddress;
    logic [3:0]        aluOpCode;
    logic              halt;
    logic [DATA_W-1:0] R15_out;
    logic              haltCondition;

    // Decoder side drives controls and observes status
    modport master (
        output writeEnable, writeSourceSelect, muxASelect, muxBSelect,
        output extInputData, destAddress, aAddress, bAddress, aluOpCode, halt,
        input  R15_out, haltCondition
    );

    // Datapath side
    modport slave (
        input  writeEnable, writeSourceSelect, muxASelect, muxBSelect,
        input  extInputData, destAddress, aAddress, bAddress, aluOpCode, halt,
        output R15_out, haltCondition
    );
endinterface

// File: rtl/alu_regfile_datapath_alu8.sv
// rtl/alu_regfile_datapath_alu8.sv - combinational 16-function ALU with zero flag
module alu8
    import alu_regfile_datapath_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [3:0]        op,
    output logic [DATA_W-1:0] result,
    output logic              zero
);
    // Function select; all arithmetic wraps at the data width
    always_comb begin
        result = '0;
        unique case (op)
            ALU_ADD:  result = a + b;
            ALU_SUB:  result = a - b;
            ALU_AND:  result = a & b;
            ALU_OR:   result = a | b;
            ALU_XOR:  result = a ^ b;
            ALU_NOT:  result = ~a;
            ALU_SHL:  result = {a[DATA_W-2:0], 1'b0};
            ALU_SHR:  result = {1'b0, a[DATA_W-1:1]};
            ALU_PASA: result = a;
            ALU_PASB: result = b;
            ALU_INC:  result = a + DATA_W'(1);
            ALU_DEC:  result = a - DATA_W'(1);
            ALU_SLT:  result = {{(DATA_W-1){1'b0}}, (a < b)};
            ALU_SEQ:  result = {{(DATA_W-1){1'b0}}, (a == b)};
            ALU_NEG:  result = ~a + DATA_W'(1);
            ALU_CLR:  result = '0;
            default:  result = '0;
        endcase
    end

    // Zero flag feeds the decoder's conditional halt
    always_comb begin
        zero = (result == '0);
    end
endmodule

// File: rtl/alu_regfile_datapath.sv
// rtl/alu_regfile_datapath.sv - register file, operand/write-back muxes and ALU
module alu_regfile_datapath
    import alu_regfile_datapath_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    alu_regfile_datapath_if.slave dp
);
    localparam int NREG = 1 << ADDR_W;

    logic [DATA_W-1:0] regs [NREG];
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic [DATA_W-1:0] alu_result;
    logic              alu_zero;
    logic [DATA_W-1:0] wb_data;

    // Combinational read ports with immediate substitution; reads see pre-edge contents
    always_comb begin
        op_a = (dp.muxASelect == SRC_EXT) ? dp.extInputData : regs[dp.aAddress];
        op_b = (dp.muxBSelect == SRC_EXT) ? dp.extInputData : regs[dp.bAddress];
    end

    alu8 #(
        .DATA_W (DATA_W)
    ) u_alu (
        .a      (op_a),
        .b      (op_b),
        .op     (dp.aluOpCode),
        .result (alu_result),
        .zero   (alu_zero)
    );

    // Write-back source select
    always_comb begin
        wb_data = (dp.writeSourceSelect == SRC_EXT) ? dp.extInputData : alu_result;
    end

    // Single write port; halt freezes all architectural state, reset clears every entry
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (dp.writeEnable && !dp.halt) begin
            regs[dp.destAddress] <= wb_data;
        end
    end

    // Status outputs straight from the register array and the ALU
    always_comb begin
        dp.R15_out       = regs[NREG-1];
        dp.haltCondition = alu_zero;
    end
endmodule

// File: tb/tb_alu_regfile_datapath.sv
// tb/tb_alu_regfile_datapath.sv - self-checking bench with behavioural register/ALU model
module tb_alu_regfile_datapath;
    import alu_regfile_datapath_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    logic [7:0] m_regs [16];
    logic [7:0] last_res;

    alu_regfile_datapath_if #(.DATA_W(8), .ADDR_W(4)) bus ();

    alu_regfile_datapath #(.DATA_W(8), .ADDR_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .dp  (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] alu_model(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        int ia;
        int ib;
        int r;
        ia = int'(a);
        ib = int'(b);
        case (op)
            4'h0: r = (ia + ib) % 256;
            4'h1: r = (ia - ib + 256) % 256;
            4'h2: r = ia & ib;
            4'h3: r = ia | ib;
            4'h4: r = ia ^ ib;
            4'h5: r = 255 - ia;
            4'h6: r = (ia * 2) % 256;
            4'h7: r = ia / 2;
            4'h8: r = ia;
            4'h9: r = ib;
            4'hA: r = (ia + 1) % 256;
            4'hB: r = (ia + 255) % 256;
            4'hC: r = (ia < ib) ? 1 : 0;
            4'hD: r = (ia == ib) ? 1 : 0;
            4'hE: r = (256 - ia) % 256;
            default: r = 0;
        endcase
        return 8'(r);
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
        end
    endtask

    // One datapath cycle: apply controls, compare against the model mid-cycle, advance model at the edge
    task automatic cyc(input logic we, input logic wsel, input logic ma, input logic mb,
                       input logic [7:0] ext, input logic [3:0] dst, input logic [3:0] aa,
                       input logic [3:0] ba, input logic [3:0] op, input logic hl);
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] res;
        bus.writeEnable       = we;
        bus.writeSourceSelect = wsel;
        bus.muxASelect        = ma;
        bus.muxBSelect        = mb;
        bus.extInputData      = ext;
        bus.destAddress       = dst;
        bus.aAddress          = aa;
        bus.bAddress          = ba;
        bus.aluOpCode         = op;
        bus.halt              = hl;
        @(negedge clk);
        a = ma ? ext : m_regs[aa];
        b = mb ? ext : m_regs[ba];
        res = alu_model(op, a, b);
        last_res = res;
        chk("cyc_halt_condition", {7'b0, bus.haltCondition}, {7'b0, (res == 8'h00)});
        chk("cyc_r15", bus.R15_out, m_regs[15]);
        @(posedge clk);
        if (rst && we && !hl) m_regs[dst] = wsel ? ext : res;
        #1;
    endtask

    logic [3:0] sw_op  [9] = '{ALU_AND, ALU_OR, ALU_XOR, ALU_SHL, ALU_SHR, ALU_NEG, ALU_SLT, ALU_NOT, ALU_PASB};
    logic [7:0] sw_exp [9] = '{8'h05, 8'hAF, 8'hAA, 8'h4A, 8'h52, 8'h5B, 8'h00, 8'h5A, 8'h0F};

    initial begin
        for (int i = 0; i < 16; i++) m_regs[i] = 8'h00;
        bus.writeEnable = 0; bus.writeSourceSelect = 0; bus.muxASelect = 0; bus.muxBSelect = 0;
        bus.extInputData = 0; bus.destAddress = 0; bus.aAddress = 0; bus.bAddress = 0;
        bus.aluOpCode = 0; bus.halt = 0;

        // Reset held across edges, then released between edges
        repeat (2) @(posedge clk);
        #1;
        chk("reset_r15", bus.R15_out, 8'h00);
        rst = 1'b1;

        cyc(0, 0, 0, 0, 8'h00, 4'd0, 4'd3, 4'd4, ALU_SEQ, 0);
        chk("reset_seq_hc", {7'b0, bus.haltCondition}, 8'h00);
        chk("reset_seq_res", last_res, 8'h01);

        // Load and add
        cyc(1, 1, 0, 0, 8'h12, 4'd1, 4'd0, 4'd0, ALU_CLR, 0);
        cyc(1, 1, 0, 0, 8'h34, 4'd2, 4'd0, 4'd0, ALU_CLR, 0);
        cyc(1, 0, 0, 0, 8'h00, 4'd15, 4'd1, 4'd2, ALU_ADD, 0);
        chk("add_r15", bus.R15_out, 8'h46);

        // Read-during-write returns old contents (model checks haltCondition against old R2)
        cyc(1, 1, 0, 0, 8'h00, 4'd2, 4'd2, 4'd0, ALU_PASA, 0);
        cyc(0, 0, 0, 0, 8'h00, 4'd0, 4'd2, 4'd0, ALU_PASA, 0);
        chk("rdw_new_zero", {7'b0, bus.haltCondition}, 8'h01);

        // Halt blocks writes
        cyc(1, 1, 0, 0, 8'h99, 4'd15, 4'd0, 4'd0, ALU_CLR, 1);
        cyc(1, 1, 0, 0, 8'h99, 4'd15, 4'd0, 4'd0, ALU_CLR, 1);
        chk("halt_r15_hold", bus.R15_out, 8'h46);
        cyc(1, 1, 0, 0, 8'h99, 4'd15, 4'd0, 4'd0, ALU_CLR, 0);
        chk("unhalt_r15", bus.R15_out, 8'h99);

        // Wrap and zero flag
        cyc(1, 1, 0, 0, 8'hFF, 4'd1, 4'd0, 4'd0, ALU_CLR, 0);
        cyc(0, 0, 0, 0, 8'h00, 4'd0, 4'd1, 4'd0, ALU_INC, 0);
        chk("inc_wrap_hc", {7'b0, bus.haltCondition}, 8'h01);
        cyc(1, 0, 0, 0, 8'h00, 4'd15, 4'd1, 4'd0, ALU_INC, 0);
        chk("inc_wrap_r15", bus.R15_out, 8'h00);
        cyc(1, 0, 1, 1, 8'h01, 4'd15, 4'd0, 4'd0, ALU_PASB, 0);
        cyc(1, 0, 0, 1, 8'h01, 4'd14, 4'd1, 4'd0, ALU_ADD, 0);
        chk("add_wrap_hc", {7'b0, bus.haltCondition}, 8'h01);
        cyc(1, 0, 0, 1, 8'h01, 4'd15, 4'd0, 4'd0, ALU_SUB, 0);
        chk("sub_wrap_r15", bus.R15_out, 8'hFF);
        cyc(1, 0, 0, 0, 8'h00, 4'd15, 4'd0, 4'd0, ALU_DEC, 0);
        chk("dec_wrap_r15", bus.R15_out, 8'hFF);

        // Operand-mux / opcode sweep with R1 = A5 and immediate B = 0F
        cyc(1, 1, 0, 0, 8'hA5, 4'd1, 4'd0, 4'd0, ALU_CLR, 0);
        for (int i = 0; i < 9; i++) begin
            cyc(1, 0, 0, 1, 8'h0F, 4'd15, 4'd1, 4'd0, sw_op[i], 0);
            chk($sformatf("sweep_op%0h", sw_op[i]), bus.R15_out, sw_exp[i]);
        end

        // Asynchronous reset between edges
        cyc(1, 1, 0, 0, 8'h99, 4'd15, 4'd0, 4'd0, ALU_CLR, 0);
        chk("pre_reset_r15", bus.R15_out, 8'h99);
        #2;
        rst = 1'b0;
        for (int i = 0; i < 16; i++) m_regs[i] = 8'h00;
        #1;
        chk("async_reset_r15", bus.R15_out, 8'h00);
        @(posedge clk);
        #1;
        cyc(1, 1, 0, 0, 8'h77, 4'd15, 4'd0, 4'd0, ALU_CLR, 0);
        chk("write_in_reset_r15", bus.R15_out, 8'h00);
        rst = 1'b1;
        cyc(0, 0, 0, 0, 8'h00, 4'd0, 4'd1, 4'd0, ALU_PASA, 0);
        chk("reset_cleared_r1_hc", {7'b0, bus.haltCondition}, 8'h01);
        cyc(1, 1, 0, 0, 8'h3C, 4'd15, 4'd0, 4'd0, ALU_CLR, 0);
        chk("post_reset_write_r15", bus.R15_out, 8'h3C);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/alu_regfile_datapath.md
Name: alu_regfile_datapath

Overview:
8-bit execution datapath of the single-cycle teaching CPU: a 16-entry register file, two operand-select muxes, a 16-function ALU and a write-back mux. It is driven by the instruction decoder's control fields and an external 8-bit input value. It exposes R15 for the seven-segment display and a zero flag used by the decoder for conditional halt. The datapath runs on the divided CPU clock.

Parameters:
DATA_W, 8, datapath and register width
ADDR_W, 4, register address width (2^ADDR_W = 16 registers)

Ports:
clk  input  1  CPU clock, rising-edge
rst  input  1  asynchronous, active-low reset
writeEnable  input  1  register write request
writeSourceSelect  input  1  write-back source: 0 = ALU result, 1 = extInputData
muxASelect  input  1  ALU operand A: 0 = reg[aAddress], 1 = extInputData
muxBSelect  input  1  ALU operand B: 0 = reg[bAddress], 1 = extInputData
extInputData  input  8  external/immediate data selected by the decoder
destAddress  input  4  write register index
aAddress  input  4  read port A index
bAddress  input  4  read port B index
aluOpCode  input  4  ALU function
halt  input  1  freezes architectural state
R15_out  output  8  current contents of register 15
haltCondition  output  1  1 when the ALU result is 0x00

Behaviour:
- Reset (rst low, asynchronous): all 16 registers clear to 0x00. R15_out reads 0x00 immediately. While rst is held low, no writes occur.
- Register file reads are combinational on both ports. A single write port commits on the rising edge of clk.
- Write occurs iff rst is high, writeEnable = 1 and halt = 0. The written data is the extInputData/ALU mux output. All registers, including R0, are writable.
- Read-during-write to the same address returns the old value. The new value is visible after the edge.
- halt = 1 blocks every write. Registers hold their values indefinitely and outputs stay combinational.
- ALU is purely combinational. Arithmetic is modulo 256 and no carry or overflow is exported. Opcodes:
  - 0 ADD A+B
  - 1 SUB A-B
  - 2 AND
  - 3 OR
  - 4 XOR
  - 5 NOT A
  - 6 SHL A by 1 (LSB 0)
  - 7 SHR A by 1 logical
  - 8 PASS A
  - 9 PASS B
  - A INC A
  - B DEC A
  - C SLT: 0x01 if A<B unsigned, else 0x00
  - D SEQ: 0x01 if A==B, else 0x00
  - E NEG A (two's complement)
  - F CLR: 0x00
- haltCondition = (ALU result == 0x00). It is combinational, independent of writeEnable and halt, and updates in the same cycle as the operands.
- R15_out is driven directly from register 15, with no extra latency after the write edge.
- Total latency: operands to written register is one clk edge. There is no pipelining and no handshake.
- Wrap-around:
  - ADD 0xFF+0x01 = 0x00 (haltCondition = 1)
  - SUB 0x00-0x01 = 0xFF
  - DEC 0x00 = 0xFF
  - INC 0xFF = 0x00
- Reset asserted mid-write: reset wins and the register ends at 0x00.

Decomposition:
- Shared package: DATA_W and ADDR_W defaults, plus 4-bit localparams for the 16 ALU opcodes (ALU_ADD … ALU_CLR) and the mux-select encodings (SRC_ALU = 0, SRC_EXT = 1).
- One sub-module, alu8: combinational, inputs a, b, op; outputs result and zero.
- The register file and muxes stay in the top of this block.

Test Plan:
- Reset: hold rst low, then release → R15_out = 0x00; SEQ of R3 and R4 gives haltCondition = 0 (result 0x01).
- Load/add:
  - Write ext 0x12 to R1 (writeSourceSelect = 1).
  - Write ext 0x34 to R2.
  - ADD R1,R2 → R15 (opcode 0, writeSourceSelect = 0).
  - Expected: R15_out = 0x46 one edge after the ADD cycle.
- Halt: with R15 = 0x46, issue write ext 0x99 to R15 with halt = 1 → R15_out stays 0x46. Drop halt and repeat → R15_out = 0x99.
- Wrap/zero flag:
  - Load 0xFF into R1 and apply INC R1.
  - Expected: result 0x00, haltCondition = 1.
  - Write the result to R15 → R15_out = 0x00.
- Mux/ops sweep:
  - Set R1 = 0xA5 and muxBSelect = 1 with ext 0x0F.
  - Expected results by opcode: AND 0x05, OR 0xAF, XOR 0xAA, SHL 0x4A, SHR 0x52, NEG 0x5B, SLT 0x00.
- Async reset mid-operation: pull rst low between clock edges with R15 = 0x99 → R15_out becomes 0x00 without any clk edge.
